// File: rtl/keypad_code_entry.sv
// keypad_code_entry: access-code entry controller downstream of the 4x4 keypad decoder.
// Optional build macro KEYPAD_PROG_EN adds code reprogramming from the unlocked state.
module keypad_code_entry #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 500_000_000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_clicked,
  input  logic [3:0]                      key_code,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic                            prog_mode,
  output logic                            err_pulse,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
  output logic [4*CODE_LEN-1:0]           entry_bcd
);

  localparam int unsigned CODE_W  = 4 * CODE_LEN;
  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
  localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] LEN_C       = CNT_W'(CODE_LEN);
  localparam logic [TRY_W-1:0] TRY_LAST    = TRY_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] UNLOCK_LAST = TMR_W'(UNLOCK_CYCLES - 1);

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_B    = 4'd13;
`ifdef KEYPAD_PROG_EN
  localparam logic [3:0] KEY_A    = 4'd12;
`endif

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    LOCKOUT  = 3'd3,
    PROGRAM  = 3'd4
  } state_t;

  state_t             state;
  logic               kstb;
  logic [TRY_W-1:0]   tries;
  logic [TMR_W-1:0]   timer;
  logic [CODE_W-1:0]  stored_code;

  logic               is_digit;
  logic [3:0]         digit_bcd;
  logic               can_append;
  logic [CODE_W-1:0]  appended;
  logic               code_match;

  // Key decode and buffer append; new digit lands in the next free nibble from the MS end
  assign is_digit   = (key_code <= 4'd9);
  assign digit_bcd  = (key_code == 4'd9) ? 4'd0 : key_code + 4'd1;
  assign can_append = (digit_count < LEN_C);
  assign appended   = entry_bcd | (CODE_W'(digit_bcd) << (4 * (CODE_LEN - 1 - 32'(digit_count))));
  assign code_match = (digit_count == LEN_C) && (entry_bcd == stored_code);

`ifndef KEYPAD_PROG_EN
  assign stored_code = DEFAULT_CODE[CODE_W-1:0];
  assign prog_mode   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kstb        <= 1'b0;
      state       <= ENTRY;
      entry_bcd   <= '0;
      digit_count <= '0;
      tries       <= '0;
      timer       <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      err_pulse   <= 1'b0;
`ifdef KEYPAD_PROG_EN
      prog_mode   <= 1'b0;
      stored_code <= DEFAULT_CODE[CODE_W-1:0];
`endif
    end else begin
      kstb      <= key_clicked;
      err_pulse <= 1'b0;
      case (state)
        ENTRY: begin
          if (kstb) begin
            if (is_digit) begin
              if (can_append) begin
                entry_bcd   <= appended;
                digit_count <= digit_count + CNT_W'(1);
              end
            end else if (key_code == KEY_STAR) begin
              entry_bcd   <= '0;
              digit_count <= '0;
            end else if (key_code == KEY_HASH) begin
              state <= CHECK;
            end
          end
        end

        // Single-cycle compare; buffer is always emptied on the way out
        CHECK: begin
          entry_bcd   <= '0;
          digit_count <= '0;
          if (code_match) begin
            state    <= UNLOCKED;
            unlocked <= 1'b1;
            tries    <= '0;
            timer    <= '0;
          end else begin
            err_pulse <= 1'b1;
            tries     <= tries + TRY_W'(1);
            if (tries == TRY_LAST) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
              timer      <= '0;
            end else begin
              state <= ENTRY;
            end
          end
        end

        // Relock expiry takes priority over a key strobe in the same cycle
        UNLOCKED: begin
          if (timer == UNLOCK_LAST) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
            if (kstb && key_code == KEY_B) begin
              state    <= ENTRY;
              unlocked <= 1'b0;
            end
`ifdef KEYPAD_PROG_EN
            else if (kstb && key_code == KEY_A) begin
              state     <= PROGRAM;
              unlocked  <= 1'b0;
              prog_mode <= 1'b1;
            end
`endif
          end
        end

        LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state      <= ENTRY;
            locked_out <= 1'b0;
            tries      <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

`ifdef KEYPAD_PROG_EN
        PROGRAM: begin
          if (kstb) begin
            if (is_digit) begin
              if (can_append) begin
                entry_bcd   <= appended;
                digit_count <= digit_count + CNT_W'(1);
              end
            end else if (key_code == KEY_STAR) begin
              entry_bcd   <= '0;
              digit_count <= '0;
            end else if (key_code == KEY_HASH) begin
              entry_bcd   <= '0;
              digit_count <= '0;
              if (digit_count == LEN_C) begin
                stored_code <= entry_bcd;
                state       <= ENTRY;
                prog_mode   <= 1'b0;
              end else begin
                err_pulse <= 1'b1;
              end
            end else if (key_code == KEY_B) begin
              entry_bcd   <= '0;
              digit_count <= '0;
              state       <= ENTRY;
              prog_mode   <= 1'b0;
            end
          end
        end
`endif

        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry with short lockout/relock timers.
// The reprogramming scenario runs only when KEYPAD_PROG_EN is defined.
module tb_keypad_code_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_clicked;
  logic [3:0]  key_code;
  logic        unlocked;
  logic        locked_out;
  logic        prog_mode;
  logic        err_pulse;
  logic [2:0]  digit_count;
  logic [15:0] entry_bcd;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0;
  int guard;

  keypad_code_entry #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (32'h0000_1234),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (20),
    .UNLOCK_CYCLES  (50)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_clicked (key_clicked),
    .key_code    (key_code),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .entry_bcd   (entry_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One click; returns in the cycle where the key's effect is first visible
  task automatic press(input logic [3:0] code);
    step();
    key_clicked = 1'b1;
    key_code    = code;
    step();
    key_clicked = 1'b0;
    step();
  endtask

  // Press n key codes, first one in the most significant used nibble of keys
  task automatic enter_code(input logic [31:0] keys, input int n);
    for (int i = n - 1; i >= 0; i--) press(keys[4*i +: 4]);
  endtask

  initial begin
    rst_n       = 1'b0;
    key_clicked = 1'b0;
    key_code    = 4'd0;
    #1;
    check("rst_unlocked", 32'(unlocked), 0);
    check("rst_locked_out", 32'(locked_out), 0);
    check("rst_count", 32'(digit_count), 0);
    check("rst_bcd", 32'(entry_bcd), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Correct code: CHECK two cycles after the # click, unlock the cycle after
    enter_code(32'h0123, 4);
    check("entry_count4", 32'(digit_count), 4);
    check("entry_bcd1234", 32'(entry_bcd), 32'h1234);
    press(4'd11);
    check("check_cycle_locked", 32'(unlocked), 0);
    step();
    check("unlock_1234", 32'(unlocked), 1);
    check("unlock_count0", 32'(digit_count), 0);
    check("unlock_no_err", 32'(err_pulse), 0);
    press(4'd13);
    check("relock_b", 32'(unlocked), 0);

    // Short code rejected with a single-cycle error pulse
    enter_code(32'h012B, 4);
    step();
    check("short_err", 32'(err_pulse), 1);
    check("short_locked", 32'(unlocked), 0);
    step();
    check("err_one_cycle", 32'(err_pulse), 0);

    // Fifth digit ignored, code still matches
    enter_code(32'h01234, 5);
    check("overflow_count", 32'(digit_count), 4);
    check("overflow_bcd", 32'(entry_bcd), 32'h1234);
    press(4'd11);
    step();
    check("overflow_unlock", 32'(unlocked), 1);
    press(4'd13);

    // Letter ignored in entry, star clears
    enter_code(32'h01, 2);
    press(4'd14);
    check("letter_ignored", 32'(digit_count), 2);
    check("partial_bcd", 32'(entry_bcd), 32'h1200);
    press(4'd10);
    check("star_count", 32'(digit_count), 0);
    check("star_bcd", 32'(entry_bcd), 0);

    // Back-to-back clicks: digit 0 then digit 9
    step();
    key_clicked = 1'b1; key_code = 4'd15;
    step();
    key_clicked = 1'b1; key_code = 4'd9;
    step();
    key_clicked = 1'b0; key_code = 4'd8;
    step();
    check("b2b_count", 32'(digit_count), 2);
    check("b2b_bcd", 32'(entry_bcd), 32'h0900);
    press(4'd10);

    // Three failures lock out for 20 cycles; correct code meanwhile ignored
    for (int k = 0; k < 3; k++) begin
      enter_code(32'h01B, 3);
      step();
    end
    check("lockout_err", 32'(err_pulse), 1);
    check("lockout_on", 32'(locked_out), 1);
    t0 = cyc;
    enter_code(32'h0123B, 5);
    check("lockout_ignore_count", 32'(digit_count), 0);
    check("lockout_still_on", 32'(locked_out), 1);
    guard = 0;
    while (locked_out && guard < 200) begin
      step();
      guard++;
    end
    check("lockout_len", 32'(cyc - t0), 20);
    check("lockout_no_unlock", 32'(unlocked), 0);
    enter_code(32'h0123B, 5);
    step();
    check("post_lockout_unlock", 32'(unlocked), 1);

    // Auto relock after 50 cycles open
    t0 = cyc;
    guard = 0;
    while (unlocked && guard < 200) begin
      step();
      guard++;
    end
    check("relock_len", 32'(cyc - t0), 50);

`ifdef KEYPAD_PROG_EN
    enter_code(32'h0123B, 5);
    step();
    press(4'd12);
    check("prog_enter", 32'(prog_mode), 1);
    check("prog_unlocked_off", 32'(unlocked), 0);
    enter_code(32'h8B, 2);
    check("prog_short_err", 32'(err_pulse), 1);
    check("prog_stay", 32'(prog_mode), 1);
    enter_code(32'h8765, 4);
    check("prog_bcd", 32'(entry_bcd), 32'h9876);
    press(4'd11);
    check("prog_exit", 32'(prog_mode), 0);
    check("prog_locked", 32'(unlocked), 0);
    enter_code(32'h0123B, 5);
    step();
    check("old_code_err", 32'(err_pulse), 1);
    enter_code(32'h8765B, 5);
    step();
    check("new_code_unlock", 32'(unlocked), 1);
    press(4'd13);
`endif

    // Asynchronous reset mid-entry clears everything without a clock edge
    enter_code(32'h01, 2);
    check("pre_rst_count", 32'(digit_count), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(digit_count), 0);
    check("async_rst_bcd", 32'(entry_bcd), 0);
    check("async_rst_outs", 32'({unlocked, locked_out, prog_mode, err_pulse}), 0);
    step();
    rst_n = 1'b1;
    enter_code(32'h0123B, 5);
    step();
    check("post_rst_default_code", 32'(unlocked), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Code-entry controller sequencing the 4x4 keypad scanner/decoder. Consumes the decoded `key_code`/`key_clicked` stream, buffers digit entry, checks a stored access code on `#`, and manages unlock, retry counting, timed lockout and optional code reprogramming. Sits directly downstream of the keypad decoder; its outputs drive the lock actuator and the 7-segment/LED status display.

## Interface
- `CODE_LEN`, 4: digits per code (1..8).
- `DEFAULT_CODE`, 32'h0000_1234: BCD code loaded at reset; low `4*CODE_LEN` bits used, first digit in the most significant nibble.
- `MAX_TRIES`, 3: consecutive failed checks before lockout (>=1).
- `LOCKOUT_CYCLES`, 100_000_000: lockout duration in clocks.
- `UNLOCK_CYCLES`, 500_000_000: auto-relock time in clocks.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_clicked`  in  1  one-cycle pulse per debounced key press.
- `key_code`  in  4  decoder code, valid from the cycle after `key_clicked`: 0..8 = digits 1..9, 9 = digit 0, 10 = `*`, 11 = `#`, 12..15 = A..D.
- `unlocked`  out  1  lock open.
- `locked_out`  out  1  lockout active, keys ignored.
- `prog_mode`  out  1  reprogramming in progress.
- `err_pulse`  out  1  one cycle per rejected check.
- `digit_count`  out  $clog2(CODE_LEN+1)  digits currently buffered.
- `entry_bcd`  out  4*CODE_LEN  buffered digits, BCD, first-entered digit in MS nibble, unused nibbles 0.

## Operation
- Internal strobe `kstb` = `key_clicked` delayed one register; `key_code` sampled only when `kstb` high.
- Digit mapping: code 0..8 -> BCD code+1; code 9 -> BCD 0.
- FSM states: ENTRY, CHECK, UNLOCKED, LOCKOUT, PROGRAM.
- ENTRY: digit appended if `digit_count < CODE_LEN`, else ignored (no shift). `*` clears buffer. `#` -> CHECK. A..D ignored.
- CHECK (one cycle): match requires `digit_count == CODE_LEN` and buffer == stored code. Match -> UNLOCKED, try counter cleared. Mismatch -> `err_pulse`, try counter +1; if counter reaches MAX_TRIES -> LOCKOUT, else ENTRY. Buffer cleared on exit either way.
- UNLOCKED: `unlocked`=1; relock timer counts from 0. `B` or timer reaching UNLOCK_CYCLES-1 -> ENTRY. `A` -> PROGRAM (when compiled in). Other keys ignored.
- LOCKOUT: `locked_out`=1; all keys discarded; after LOCKOUT_CYCLES clocks -> ENTRY, try counter cleared.
- PROGRAM: digits/`*` as in ENTRY. `#` with `digit_count == CODE_LEN` -> stored code := buffer, -> ENTRY (locked). `#` with wrong count -> `err_pulse`, buffer cleared, stay PROGRAM, try counter unchanged. `B` -> ENTRY, code unchanged.
- Reset (any time, incl. mid-entry/lockout): state ENTRY, buffer/counters/timers 0, stored code := DEFAULT_CODE, all outputs 0.

## Timing
- `key_clicked` high in cycle n -> `kstb` in n+1 -> buffer/`digit_count`/state update visible n+2.
- `#` at n: CHECK in n+2; `unlocked` or `err_pulse`/`locked_out` visible n+3.
- Back-to-back `key_clicked` pulses each processed in order; a key whose `kstb` lands in CHECK is discarded.
- Relock-timer expiry and key strobe in same cycle: expiry wins, key discarded.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles of `locked_out`=1.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `KEYPAD_PROG_EN` defined: PROGRAM state, `A` handling and writable code register present.
- Undefined: `A` ignored in UNLOCKED, `prog_mode` tied 0, stored code constant DEFAULT_CODE.

## Test plan
- Reset, keys 1,2,3,4,# (codes 0,1,2,3,11) -> `unlocked`=1 three cycles after `#` pulse; `digit_count` back to 0.
- Keys 1,2,3,# -> one `err_pulse`, `unlocked`=0; keys 1,2,3,4,5,# -> fifth digit ignored, unlock.
- Three wrong codes (MAX_TRIES=3, LOCKOUT_CYCLES=20) -> `locked_out`=1 for 20 cycles; correct code during lockout ignored; correct code afterwards unlocks.
- Unlock, press `B` -> `unlocked`=0; unlock with UNLOCK_CYCLES=50, no keys -> relock at cycle 50.
- `KEYPAD_PROG_EN`: unlock, A, 9,8,7,6 (codes 8,7,6,5), # -> locked; 1234 fails, 9876 unlocks; reset -> 1234 works again.
- Assert `rst_n` low mid-entry after 2 digits -> `digit_count`=0, `entry_bcd`=0 immediately, all outputs 0.
